// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, FSM states and STATUS layout shared by the MMIO responder.
package mmio_pkg;
  localparam logic [3:0] OFF_LED = 4'h0;
  localparam logic [3:0] OFF_TIMER = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_COUNT = 2;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO feeding the console; head reads as zero while empty.
module tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: single-outstanding MMIO slave with LED, TIMER, console TX and STATUS registers.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [31:0] timer, rdata_q, rd, status;
  logic err_q, accept, bad, wr_ok, push, full, empty;
  logic [3:0] off;
  logic [CW-1:0] count;
  assign accept = req_valid && req_ready;
  assign off = req_addr[3:0];
  assign bad = req_addr[31:4] != BASE_ADDR[31:4] || req_addr[1:0] != 2'b00 ||
               (off == OFF_TXDATA && (!req_wren || full)) || (off == OFF_STATUS && req_wren);
  assign wr_ok = accept && req_wren && !bad;
  assign push = wr_ok && off == OFF_TXDATA;
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_COUNT +: 3] = 3'(count);
  end
  assign rd = (bad || req_wren) ? 32'h0 :
              off == OFF_LED   ? {22'b0, leds} :
              off == OFF_TIMER ? timer : status;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb state_nx = (state == IDLE && req_valid) ? RESP : IDLE;
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_rdata = state == RESP ? rdata_q : 32'h0;
    rsp_err = state == RESP && err_q;
  end
  // Load data is snapshotted at accept so TIMER reads reflect the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '0;
      timer <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      timer <= (wr_ok && off == OFF_TIMER) ? 32'h0 : timer + 32'h1;
      if (wr_ok && off == OFF_LED) leds <= req_wdata[9:0];
      if (accept) begin
        rdata_q <= rd;
        err_q <= bad;
      end
    end
  end
  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(req_wdata[7:0]),
    .pop(tx_valid && tx_ready), .head(tx_data), .count(count), .full(full), .empty(empty)
  );
  assign tx_valid = !empty;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed and randomized checks of mmio_responder against a queue/arithmetic reference model.
module tb_mmio_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wren = 0, tx_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, tx_valid;
  logic [31:0] rsp_rdata;
  logic [9:0] leds;
  logic [7:0] tx_data;
  int n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0, t_cyc = 0;
  logic [31:0] t_val = 0;
  logic [9:0] m_leds = 0;
  byte unsigned q[$];
  logic push_pend = 0;
  logic [7:0] push_byte = 0;
  logic v, e, ee;
  logic [31:0] r, er;
  logic [9:0] led_obs;

  mmio_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .leds(leds), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Reference FIFO: pop decided on pre-edge occupancy, then the accepted push lands.
  always @(posedge clk) begin
    cyc++;
    if (rst) q.delete();
    else begin
      if (tx_ready && q.size() > 0) void'(q.pop_front());
      if (push_pend) q.push_back(push_byte);
    end
    push_pend = 0;
  end

  function automatic logic [31:0] exp_timer();
    return t_val + 32'(cyc - t_cyc);
  endfunction

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int sz;
    logic [3:0] off;
    sz = q.size();
    off = addr[3:0];
    ee = addr[31:4] != BASE[31:4] || addr[1:0] != 2'b00 ||
         (off == 4'h8 && (!wr || sz == DEPTH)) || (off == 4'hC && wr);
    er = 32'h0;
    if (!ee && !wr)
      er = off == 4'h0 ? {22'b0, m_leds} : off == 4'h4 ? exp_timer() :
           {27'b0, 3'(sz), sz == 0, sz == DEPTH};
    push_pend = wr && !ee && off == 4'h8;
    push_byte = wdata[7:0];
    req_valid = 1; req_wren = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    if (wr && !ee && off == 4'h0) m_leds = wdata[9:0];
    if (wr && !ee && off == 4'h4) begin t_val = 0; t_cyc = cyc; end
    v = rsp_valid; r = rsp_rdata; e = rsp_err; led_obs = leds;
    req_wren = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", rsp_err); end
    n_cmp++; if (leds !== 10'h0) begin n_bad++; $display("FAIL rst_leds got %h want 0", leds); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h0) begin n_bad++; $display("FAIL rst_tx_data got %h want 0", tx_data); end
    rst = 0; t_val = 0; t_cyc = cyc; m_leds = 0;
  endtask

  task automatic test_timer_read();
    repeat (10) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL pre_rsp got %b want 0", rsp_valid); end
    access(0, BASE + 4, 0);
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL timer_vld got %b want 1", v); end
    n_cmp++; if (r !== 32'd10) begin n_bad++; $display("FAIL timer_10 got %0d want 10", r); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL timer_err got %b want 0", e); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_rsp got %b want 0", rsp_valid); end
  endtask

  task automatic test_led();
    access(1, BASE, 32'hFFFF_F2AB);
    n_cmp++; if (e !== 1'b0 || r !== 32'h0) begin n_bad++; $display("FAIL led_st got %b/%h want 0/0", e, r); end
    n_cmp++; if (led_obs !== 10'h2AB) begin n_bad++; $display("FAIL led_out got %h want 2ab", led_obs); end
    access(0, BASE, 0);
    n_cmp++; if (r !== 32'h0000_02AB) begin n_bad++; $display("FAIL led_ld got %h want 2ab", r); end
  endtask

  task automatic test_fifo();
    logic [7:0] b;
    tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'h41 + 8'(i);
      access(1, BASE + 8, {24'h0, b});
      n_cmp++; if (e !== (i == 4)) begin n_bad++; $display("FAIL tx_push%0d err got %b want %b", i, e, i == 4); end
    end
    access(0, BASE + 12, 0);
    n_cmp++; if (r !== 32'h11) begin n_bad++; $display("FAIL status_full got %h want 11", r); end
    n_cmp++; if (r !== er) begin n_bad++; $display("FAIL status_model got %h want %h", r, er); end
    n_cmp++; if (tx_data !== 8'h41) begin n_bad++; $display("FAIL tx_hold got %h want 41", tx_data); end
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin
        n_bad++; $display("FAIL drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 8'h41 + 8'(i));
      end
      @(negedge clk);
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %b want 0", tx_valid); end
    tx_ready = 0;
    access(0, BASE + 12, 0);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL status_empty got %h want 2", r); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic wrs [4];
    addrs = '{BASE + 32'h10, BASE + 2, BASE + 8, BASE + 12};
    wrs = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      access(wrs[i], addrs[i], 32'hFFFF_FFFF);
      n_cmp++;
      if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin
        n_bad++; $display("FAIL err%0d got v%b e%b %h want v1 e1 0", i, v, e, r);
      end
    end
    access(1, BASE + 32'h10, 32'h155);
    n_cmp++; if (e !== 1'b1 || leds !== m_leds) begin n_bad++; $display("FAIL err_led got %b/%h want 1/%h", e, leds, m_leds); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL err_fifo got %b want 0", tx_valid); end
  endtask

  task automatic test_timer_wrap();
    @(negedge clk);
    force dut.timer = 32'hFFFF_FFFE;
    #1 release dut.timer;
    t_val = 32'hFFFF_FFFE; t_cyc = cyc;
    repeat (2) @(negedge clk);
    access(0, BASE + 4, 0);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL timer_wrap got %h want 0", r); end
    access(1, BASE + 4, $urandom);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL timer_st got %b want 0", e); end
    access(0, BASE + 4, 0);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL timer_clr got %h want 1", r); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      tx_ready = 1'($urandom);
      case ($urandom_range(0, 6))
        0, 1: a = BASE + 8;
        2: a = BASE + {$urandom_range(0, 3), 2'b00};
        3: a = BASE + {$urandom_range(0, 3), 2'b00} + $urandom_range(1, 3);
        4: a = $urandom;
        default: a = BASE + 12;
      endcase
      access(1'($urandom), a, $urandom);
      n_cmp++;
      if (v !== 1'b1 || r !== er || e !== ee) begin
        n_bad++; $display("FAIL rnd%0d a=%h got v%b %h e%b want v1 %h e%b", i, a, v, r, e, er, ee);
      end
      n_cmp++; if (led_obs !== m_leds) begin n_bad++; $display("FAIL rnd_led%0d got %h want %h", i, led_obs, m_leds); end
      n_cmp++;
      if (tx_valid !== (q.size() > 0) || (q.size() > 0 && tx_data !== q[0])) begin
        n_bad++; $display("FAIL rnd_tx%0d got %b/%h want %b", i, tx_valid, tx_data, q.size() > 0);
      end
    end
  endtask

  task automatic test_reset_in_resp();
    tx_ready = 1;
    repeat (DEPTH + 1) @(negedge clk);
    tx_ready = 0;
    access(1, BASE + 8, 32'h55);
    access(1, BASE, 32'h3FF);
    req_valid = 1; req_wren = 0; req_addr = BASE;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rr_pending got %b want 1", rsp_valid); end
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || leds !== 10'h0 || tx_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL rr_reset got v%b rdy%b leds%h tx%b rd%h want v0 rdy1 0 0 0", rsp_valid, req_ready, leds, tx_valid, rsp_rdata);
    end
    req_valid = 1; req_wren = 1; req_addr = BASE + 8; req_wdata = 32'h77;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_override got %b/%b want 0/0", tx_valid, rsp_valid); end
    rst = 0; req_valid = 0; t_val = 0; t_cyc = cyc; m_leds = 0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_no_rsp got %b want 0", rsp_valid); end
    access(0, BASE + 4, 0);
    n_cmp++; if (r !== er || r !== 32'd1) begin n_bad++; $display("FAIL rr_timer got %h want %h", r, er); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_timer_read();
    test_led();
    test_fifo();
    test_errors();
    test_timer_wrap();
    test_random();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
